display_driver_7seg: RTL and testbench
======================================

Name: display_driver_7seg

Overview:
- Downstream stage of the reverse-polish calculator top. Consumes its 16-bit ToDisplay word and drives a multiplexed 8-digit common-anode 7-segment display.
- Shows the word as hexadecimal (4 digits) or unsigned decimal (5 digits).
- Decimal digits come from a sequential shift-add-3 (double-dabble) converter, so no large combinational divider is needed.
- The shown digits only change when a conversion completes, which keeps the display glitch-free.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays active (min 2).
- NUM_DIGITS, 8, number of anode positions scanned (min 5, max 8).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- value  input  16  word to display (ToDisplay of the calculator).
- dec_mode  input  1  1 = unsigned decimal, 0 = hexadecimal.
- an  output  NUM_DIGITS  anode enables, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held 1 (off).
- busy  output  1  high while a decimal conversion is in progress.

Behaviour:
- Reset (reset=0, async) sets:
  - an all 1s, seg 7'h7F, dp 1, busy 0.
  - Shown-digit registers 0; latched value 0; latched mode hex.
  - Refresh counter 0; digit index 0.
- FSM states are IDLE, CONV, DONE.
- IDLE:
  - Each cycle, compare the (value, dec_mode) input pair with the latched pair.
  - On mismatch with dec_mode=0: latch the pair, load the shown digits directly from the nibbles (digit i = value[4i+3:4i]) on that edge, and stay in IDLE. Hex latency is 1 cycle.
  - On mismatch with dec_mode=1: latch the pair, clear a 20-bit BCD scratch, load the shift register with value, clear the iteration counter, and go to CONV.
- CONV:
  - busy=1.
  - Each cycle, add 3 to every scratch BCD nibble that is ≥5, then shift {bcd,shift} left by 1.
  - After exactly 16 iterations, go to DONE.
- DONE:
  - Copy the 5 BCD nibbles to shown digits 0..4 and go to IDLE.
  - busy falls on the cycle after the copy.
  - Latency from mismatch edge to updated digits is 18 cycles.
- Input change during CONV is ignored mid-flight. The IDLE comparison catches it afterwards and starts a new conversion. No conversion is ever aborted except by reset.
- Reset mid-conversion returns the FSM to IDLE with shown digits 0.
- Significant digits are 0..3 in hex and 0..4 in decimal. Non-significant positions are blanked: anode held 1 during their slot, seg 7'h7F.
- Refresh scan:
  - Counter counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, digit index increments modulo NUM_DIGITS (NUM_DIGITS-1 → 0).
  - an[idx]=0 and all other anodes are 1.
  - seg is registered from the digit at idx; an and seg change on the same edge.
- Segment codes, active-low:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
  - A=08 b=03 C=46 d=21 E=06 F=0E
- The scan runs independently of the FSM. The scan reads the shown-digit registers only.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: significant digits above the most significant nonzero digit are also blanked (anode 1, seg 7F). Digit 0 is always shown, so a value of 0 shows a single "0". The blank decision uses the shown digits, not the live input.
- Undefined: all 4 (hex) or 5 (decimal) significant digits are always shown, including leading zeros.

Test Plan:
- Reset with REFRESH_DIV=4, value=0, hex → after release: an steps FE, FD, FB, F7 with seg 40; positions 4–7 are anode-high; the index wraps to 0 after 32 cycles.
- value=16'hBEEF, hex → next edge digits 0..3 = F,E,E,B; seg 0E,06,06,03; busy stays 0.
- value=16'd65535, decimal → busy high for 17 cycles; after 18 cycles digits 0..4 = 5,3,5,5,6; seg 12,30,12,12,02.
- Decimal 12345; change value to 9 during cycle 5 of CONV → 12345 shown first; then a second conversion; final digits 9,0,0,0,0.
- Assert reset for 1 cycle mid-conversion (decimal 500) → outputs immediately take reset values; no stale digits appear afterwards; the pair is then re-converted (500).
- With LEADING_ZERO_BLANK_EN, decimal 42 → only digits 0,1 are lit (seg 19, 24); value 0 → only digit 0 lit with seg 40.

Source files
------------

// File: rtl/display_driver_7seg_if.sv
// rtl/display_driver_7seg_if.sv - value/mode in, anode/segment/busy out bundle for the 7-seg driver
interface display_driver_7seg_if #(
  parameter int NUM_DIGITS = 8
);
  logic [15:0]           value;
  logic                  dec_mode;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  busy;

  modport master (output value, dec_mode, input an, seg, dp, busy);
  modport slave  (input value, dec_mode, output an, seg, dp, busy);
endinterface

// File: rtl/display_driver_7seg.sv
// rtl/display_driver_7seg.sv - multiplexed 7-seg driver, hex or double-dabble decimal view
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module display_driver_7seg #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input logic                  clk,
  input logic                  reset,
  display_driver_7seg_if.slave disp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     r_lat_value;
  logic            r_lat_mode;
  logic [19:0]     r_bcd;
  logic [15:0]     r_shift;
  logic [3:0]      r_iter;
  logic [3:0]      r_digit [5];
  logic            r_shown_dec;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_idx;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]      r_seg;

  logic            w_mismatch;
  logic            w_load_hex;
  logic            w_start_conv;
  logic            w_step;
  logic            w_copy;
  logic            w_busy;
  logic [19:0]     w_bcd_adj;
  logic [3:0]      w_cur_digit;
  logic [2:0]      w_sig_lim;
  logic            w_blank;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: seg_code = 7'h40;
      4'h1: seg_code = 7'h79;
      4'h2: seg_code = 7'h24;
      4'h3: seg_code = 7'h30;
      4'h4: seg_code = 7'h19;
      4'h5: seg_code = 7'h12;
      4'h6: seg_code = 7'h02;
      4'h7: seg_code = 7'h78;
      4'h8: seg_code = 7'h00;
      4'h9: seg_code = 7'h10;
      4'hA: seg_code = 7'h08;
      4'hB: seg_code = 7'h03;
      4'hC: seg_code = 7'h46;
      4'hD: seg_code = 7'h21;
      4'hE: seg_code = 7'h06;
      default: seg_code = 7'h0E;
    endcase
  endfunction

  assign w_mismatch = (disp.value != r_lat_value) || (disp.dec_mode != r_lat_mode);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load_hex   = 1'b0;
    w_start_conv = 1'b0;
    w_step       = 1'b0;
    w_copy       = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mismatch) begin
          if (disp.dec_mode) begin
            w_start_conv = 1'b1;
            w_state_next = CONV;
          end else begin
            w_load_hex = 1'b1;
          end
        end
      end
      CONV: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (r_iter == 4'd15) w_state_next = DONE;
      end
      DONE: begin
        w_busy       = 1'b1;
        w_copy       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Add-3 correction applied before each shift keeps every nibble a valid BCD digit.
  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < 5; i++) begin
      w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_value <= '0;
      r_lat_mode  <= 1'b0;
      r_bcd       <= '0;
      r_shift     <= '0;
      r_iter      <= '0;
      r_shown_dec <= 1'b0;
      for (int i = 0; i < 5; i++) r_digit[i] <= '0;
    end else begin
      if (w_load_hex || w_start_conv) begin
        r_lat_value <= disp.value;
        r_lat_mode  <= disp.dec_mode;
      end
      if (w_load_hex) begin
        for (int i = 0; i < 4; i++) r_digit[i] <= disp.value[4*i +: 4];
        r_shown_dec <= 1'b0;
      end
      if (w_start_conv) begin
        r_bcd   <= '0;
        r_shift <= disp.value;
        r_iter  <= '0;
      end
      if (w_step) begin
        {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
        r_iter           <= r_iter + 4'd1;
      end
      if (w_copy) begin
        for (int i = 0; i < 5; i++) r_digit[i] <= r_bcd[4*i +: 4];
        r_shown_dec <= 1'b1;
      end
    end
  end

  always_comb begin
    case (r_idx)
      3'd0:    w_cur_digit = r_digit[0];
      3'd1:    w_cur_digit = r_digit[1];
      3'd2:    w_cur_digit = r_digit[2];
      3'd3:    w_cur_digit = r_digit[3];
      3'd4:    w_cur_digit = r_digit[4];
      default: w_cur_digit = 4'd0;
    endcase
  end

  assign w_sig_lim = r_shown_dec ? 3'd5 : 3'd4;

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] w_msd;

  // Highest nonzero significant digit of what is shown; stays 0 for an all-zero value.
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < 5; i++) begin
      if ((3'(i) < w_sig_lim) && (r_digit[i] != 4'd0)) w_msd = 3'(i);
    end
  end

  assign w_blank = (r_idx >= w_sig_lim) || (r_idx > w_msd);
`else
  assign w_blank = (r_idx >= w_sig_lim);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= 7'h7F;
    end else begin
      if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_an  <= w_blank ? '1 : ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_blank ? 7'h7F : seg_code(w_cur_digit);
    end
  end

  assign disp.an   = r_an;
  assign disp.seg  = r_seg;
  assign disp.dp   = 1'b1;
  assign disp.busy = w_busy;

endmodule

// File: tb/tb_display_driver_7seg.sv
// tb/tb_display_driver_7seg.sv - directed bench for display_driver_7seg (REFRESH_DIV=4, 8 digits)
module tb_display_driver_7seg;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [6:0] exp_seg [8];

  display_driver_7seg_if #(.NUM_DIGITS(8)) dif ();

  display_driver_7seg #(.REFRESH_DIV(4), .NUM_DIGITS(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .disp  (dif)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan slot after edge n is ((n-1)/4) mod 8.
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                         input logic [6:0] s6, input logic [6:0] s7);
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    exp_seg[4] = s4; exp_seg[5] = s5; exp_seg[6] = s6; exp_seg[7] = s7;
  endtask

  task automatic frame(input string tag, input int n);
    int p;
    logic [7:0] ea;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      p  = ((cyc - 1) >> 2) % 8;
      ea = (exp_seg[p] == 7'h7F) ? 8'hFF : ~(8'h01 << p);
      chk({tag, "_an"}, {24'd0, dif.an}, {24'd0, ea});
      chk({tag, "_seg"}, {25'd0, dif.seg}, {25'd0, exp_seg[p]});
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (dif.busy !== 1'b0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, dif.busy}, 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    dif.value    = 16'h0000;
    dif.dec_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", {24'd0, dif.an}, 32'hFF);
    chk("rst_seg", {25'd0, dif.seg}, 32'h7F);
    chk("rst_dp", {31'd0, dif.dp}, 32'd1);
    chk("rst_busy", {31'd0, dif.busy}, 32'd0);
    reset = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`else
    set_exp(7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`endif
    frame("scan_zero", 36);

    dif.value = 16'hBEEF;
    @(negedge clk);
    chk("hex_busy", {31'd0, dif.busy}, 32'd0);
    @(negedge clk);
    set_exp(7'h0E, 7'h06, 7'h06, 7'h03, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    frame("hex_beef", 32);

    dif.value    = 16'd65535;
    dif.dec_mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("dec_busy_hi", {31'd0, dif.busy}, 32'd1);
    end
    @(negedge clk);
    chk("dec_busy_lo", {31'd0, dif.busy}, 32'd0);
    set_exp(7'h12, 7'h30, 7'h12, 7'h12, 7'h02, 7'h7F, 7'h7F, 7'h7F);
    frame("dec_65535", 32);

    dif.value = 16'd12345;
    repeat (5) @(negedge clk);
    dif.value = 16'd9;
    repeat (13) @(negedge clk);
    chk("mid_busy_gap", {31'd0, dif.busy}, 32'd0);
    @(negedge clk);
    chk("mid_busy_restart", {31'd0, dif.busy}, 32'd1);
    set_exp(7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F);
    frame("dec_12345", 17);
    wait_idle("idle_9", 40);
    repeat (2) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`else
    set_exp(7'h10, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F);
`endif
    frame("dec_9", 32);

    dif.value = 16'd500;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid_an", {24'd0, dif.an}, 32'hFF);
    chk("rstmid_seg", {25'd0, dif.seg}, 32'h7F);
    chk("rstmid_busy", {31'd0, dif.busy}, 32'd0);
    chk("rstmid_dp", {31'd0, dif.dp}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`else
    set_exp(7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`endif
    frame("rstmid_zero", 1);
    chk("reconv_busy", {31'd0, dif.busy}, 32'd1);
    frame("rstmid_zero", 16);
    wait_idle("idle_500", 40);
    repeat (2) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(7'h40, 7'h40, 7'h12, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`else
    set_exp(7'h40, 7'h40, 7'h12, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F);
`endif
    frame("dec_500", 32);

    dif.value = 16'd42;
    @(negedge clk);
    chk("busy_42", {31'd0, dif.busy}, 32'd1);
    wait_idle("idle_42", 40);
    repeat (2) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(7'h24, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`else
    set_exp(7'h24, 7'h19, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F);
`endif
    frame("dec_42", 32);

    dif.value = 16'd0;
    @(negedge clk);
    chk("busy_0", {31'd0, dif.busy}, 32'd1);
    wait_idle("idle_0", 40);
    repeat (2) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`else
    set_exp(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F);
`endif
    frame("dec_0", 32);

    dif.dec_mode = 1'b0;
    @(negedge clk);
    chk("hex0_busy", {31'd0, dif.busy}, 32'd0);
    @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    set_exp(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`else
    set_exp(7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`endif
    frame("hex_0", 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
